// File: rtl/mips_mem_pkg.sv
// Shared encodings, FSM state type and store merge helper for the MIPS load/store unit.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    LD_DONE = 3'd2,
    MERGE   = 3'd3,
    WR      = 3'd4,
    ERR     = 3'd5
  } lsu_state_t;

  // Overlay the right-aligned store data onto the addressed lanes of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [4:0]  sh;
    logic [31:0] mask;
    sh = {lane, 3'b000};
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF << sh;
      SZ_HALF: mask = 32'h0000_FFFF << sh;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old_word & ~mask) | ((wdata << sh) & mask);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select with sign/zero extension (little-endian lanes).
module lsu_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = rdata_i >> {lane_i, 3'b000};
    result_o = 32'h0;
    case (size_i)
      SZ_BYTE: result_o = unsigned_i ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result_o = unsigned_i ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: result_o = rdata_i;
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// Memory-stage load/store unit: byte-addressed MIPS accesses to a word-wide single-port memory,
// with read-modify-write for sub-word stores and a one-cycle response pulse.
module mips_load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  lsu_state_t  state_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        acc_err;
  logic [31:0] load_res;

  assign acc_err = (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                || (req_size == 2'b11)
                || (req_addr[31:2] >= DEPTH_W);

  lsu_load_align u_align (
    .rdata_i    (mem_read_data),
    .size_i     (size_q),
    .lane_i     (addr_q[1:0]),
    .unsigned_i (uns_q),
    .result_o   (load_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= 32'h0;
      size_q       <= 2'b00;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            write_q <= req_write;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            if (acc_err)                               state_q <= ERR;
            else if (req_write && req_size == SZ_WORD) state_q <= WR;
            else                                       state_q <= RD;
          end
        end
        RD:      state_q <= write_q ? MERGE : LD_DONE;
        LD_DONE: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_res;
          state_q      <= IDLE;
        end
        // The merged word replaces the store data so WR drives wdata_q unconditionally.
        MERGE: begin
          wdata_q <= store_merge(mem_read_data, wdata_q, size_q, addr_q[1:0]);
          state_q <= WR;
        end
        WR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
          state_q      <= IDLE;
        end
        ERR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_rdata_q <= 32'h0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign mem_read       = (state_q == RD);
  assign mem_write      = (state_q == WR);
  assign mem_write_data = wdata_q;
  assign mem_addr       = {2'b00, addr_q[31:2]};
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit with a byte-level memory model and per-cycle response checker.
module tb_mips_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  always #5 clk = ~clk;

  mips_load_store_unit #(.DEPTH(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // Single-port memory with registered read data.
  logic [31:0] mem [0:127];
  logic [31:0] mem_rd_q = 32'h0;
  always @(posedge clk) begin
    if (mem_read && mem_addr < 32'd128) mem_rd_q <= mem[mem_addr[6:0]];
    if (mem_write && mem_addr < 32'd128) mem[mem_addr[6:0]] <= mem_write_data;
  end
  assign mem_read_data = mem_rd_q;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory and queue of expected responses.
  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t        expq[$];
  logic [7:0]  mb [0:511];

  task automatic model_req(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input int acc);
    exp_t   e;
    int     n;
    longint v;
    logic   err;
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
       || ((a >> 2) >= 32'd128);
    e.err   = err;
    e.rdata = 32'h0;
    n = 1 << sz;
    if (err) begin
      e.due = acc + 1;
    end else if (!w) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(mb[int'(a) + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      e.rdata = v[31:0];
      e.due   = acc + 2;
    end else begin
      for (int i = 0; i < n; i++) mb[int'(a) + i] = 8'(wd >> (8 * i));
      e.due = (sz == 2'b10) ? acc + 1 : acc + 3;
    end
    expq.push_back(e);
  endtask

  // Per-cycle response checker and strobe monitor.
  logic        due_now;
  logic [31:0] last_rdata, last_rd_addr, last_wr_data;
  logic        last_err;
  int          resp_cnt = 0, resp_cyc = 0, rd_cnt = 0, wr_cnt = 0, last_acc = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      due_now = (expq.size() > 0) && (expq[0].due == cyc);
      chk("resp_valid", {31'h0, resp_valid}, {31'h0, due_now});
      if (due_now) begin
        if (resp_valid) begin
          chk("resp_err", {31'h0, resp_err}, {31'h0, expq[0].err});
          chk("resp_rdata", resp_rdata, expq[0].rdata);
        end
        void'(expq.pop_front());
      end
      if (resp_valid) begin
        last_rdata = resp_rdata;
        last_err   = resp_err;
        resp_cnt++;
        resp_cyc   = cyc;
      end
      if (mem_read)  begin rd_cnt++; last_rd_addr = mem_addr; end
      if (mem_write) begin wr_cnt++; last_wr_data = mem_write_data; end
      chk("strobe_excl", {31'h0, mem_read & mem_write}, 32'h0);
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input bit track);
    int tries;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    tries = 0;
    while (!req_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'h1, 32'h0);
      req_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    if (track) model_req(w, sz, uns, a, wd, last_acc);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) begin
      chk("resp_timeout", 32'h1, 32'h0);
      expq.delete();
    end
  endtask

  task automatic clr_cnt();
    rd_cnt = 0; wr_cnt = 0;
  endtask

  int acc1, rc0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[4] = 32'h8844_22F1;
    mem[5] = 32'h5566_7788;
    for (int i = 0; i < 128; i++)
      for (int b = 0; b < 4; b++) mb[i*4+b] = 8'(mem[i] >> (8 * b));

    #12;
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk); rst_n = 1'b1;

    // Byte loads with sign and zero extension.
    clr_cnt();
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b1); wait_done();
    chk("lb_0x10", last_rdata, 32'hFFFF_FFF1);
    chk("lb_latency", 32'(resp_cyc - last_acc), 32'd2);
    chk("lb_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("lb_mem_addr", last_rd_addr, 32'd4);
    clr_cnt();
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1); wait_done();
    chk("lbu_0x13", last_rdata, 32'h0000_0088);
    chk("lbu_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("lbu_mem_addr", last_rd_addr, 32'd4);

    // Half loads.
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1); wait_done();
    chk("lh_0x12", last_rdata, 32'hFFFF_8844);
    chk("lh_err", {31'h0, last_err}, 32'h0);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1); wait_done();
    chk("lhu_0x12", last_rdata, 32'h0000_8844);

    // Sub-word store via read-modify-write.
    clr_cnt();
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 1'b1); wait_done();
    chk("sb_latency", 32'(resp_cyc - last_acc), 32'd3);
    chk("sb_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("sb_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("sb_wr_data", last_wr_data, 32'h8844_ABF1);
    chk("sb_mem4", mem[4], 32'h8844_ABF1);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1); wait_done();
    chk("lw_after_sb", last_rdata, 32'h8844_ABF1);

    // Errors: misaligned word load, out-of-range word store.
    clr_cnt();
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1); wait_done();
    chk("lw_mis_err", {31'h0, last_err}, 32'h1);
    chk("lw_mis_rdata", last_rdata, 32'h0);
    chk("lw_mis_latency", 32'(resp_cyc - last_acc), 32'd1);
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h1234_5678, 1'b1); wait_done();
    chk("sw_oor_err", {31'h0, last_err}, 32'h1);
    chk("sw_oor_latency", 32'(resp_cyc - last_acc), 32'd1);
    chk("err_no_strobes", 32'(rd_cnt + wr_cnt), 32'd0);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1); wait_done();
    chk("bad_size_err", {31'h0, last_err}, 32'h1);

    // Back-to-back: the store is accepted in the same cycle as the load's response.
    rc0 = resp_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
    acc1 = last_acc;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b1);
    chk("b2b_accept_cycle", 32'(last_acc), 32'(acc1 + 3));
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1); wait_done();
    chk("b2b_lw_0x20", last_rdata, 32'hDEAD_BEEF);
    chk("b2b_resp_cnt", 32'(resp_cnt - rc0), 32'd3);

    // Reset during MERGE abandons the store.
    rc0 = resp_cnt;
    clr_cnt();
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_1234, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("mid_rst_rdata", resp_rdata, 32'h0);
    chk("mid_rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_resp", 32'(resp_cnt - rc0), 32'd0);
    chk("mid_rst_no_write", 32'(wr_cnt), 32'd0);
    chk("mid_rst_mem5", mem[5], 32'h5566_7788);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1); wait_done();
    chk("lw_after_rst", last_rdata, 32'h5566_7788);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
